// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit ripple adder, one nibble per clock, LSB nibble first; done pulses NIBBLES+1 cycles after start.
// No backpressure: start is ignored while busy. Optional subtract path under `SERIAL_ADD_SUB_EN`.

module Ripple_Adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       C_out
);
  logic [4:0] c;

  assign c[0] = C_in;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign C_out = c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 C_in,
  input  logic                 sub,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] S,
  output logic                 C_out,
  output logic                 overflow
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_sh, b_sh, res_sh;
  logic [W-1:0]    b_eff;
  logic [W+3:0]    res_cat;
  logic [CW-1:0]   cnt;
  logic            carry, c_eff;
  logic            a_msb, b_msb;
  logic [3:0]      nib_s;
  logic            nib_c;
  logic            accept, last;

`ifdef SERIAL_ADD_SUB_EN
  assign b_eff = sub ? ~B : B;
  assign c_eff = sub ? 1'b1 : C_in;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff = B;
  assign c_eff = C_in;
`endif

  assign accept  = start && (state != ADD);
  assign last    = (cnt == CW'(NIBBLES - 1));
  assign busy    = (state == ADD);
  assign done    = (state == DONE);
  // New sum nibble enters at the top so the LSB nibble ends up at the bottom.
  assign res_cat = {nib_s, res_sh};

  Ripple_Adder u_adder (
    .A     (a_sh[3:0]),
    .B     (b_sh[3:0]),
    .C_in  (carry),
    .S     (nib_s),
    .C_out (nib_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (last)  state_next = DONE;
      DONE:    state_next = start ? ADD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      S        <= '0;
      C_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= b_eff;
      carry <= c_eff;
      cnt   <= '0;
      // Operand sign bits are shifted out before the end, so keep them for overflow.
      a_msb <= A[W-1];
      b_msb <= b_eff[W-1];
    end else if (state == ADD) begin
      a_sh   <= a_sh >> 4;
      b_sh   <= b_sh >> 4;
      res_sh <= res_cat[W+3:4];
      carry  <= nib_c;
      cnt    <= cnt + CW'(1);
      if (last) begin
        S        <= res_cat[W+3:4];
        C_out    <= nib_c;
        overflow <= (a_msb == b_msb) && (nib_s[3] != a_msb);
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4): directed vectors, queued expectations, done-driven monitor.

module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst, start, C_in, sub;
  logic [15:0] A, B;
  logic        busy, done, C_out, overflow;
  logic [15:0] S;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] cyc = 0;
  int          checks = 0;
  int          errors = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C_in(C_in), .sub(sub),
    .busy(busy), .done(done), .S(S), .C_out(C_out), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("S", {16'h0, S}, {16'h0, e.s});
          check("C_out", {31'h0, C_out}, {31'h0, e.c});
          check("overflow", {31'h0, overflow}, {31'h0, e.v});
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Drive one start pulse at a negedge; acceptance is the next edge, done 4 edges later.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sb,
                       input logic [15:0] es, input logic ec, input logic ev);
    exp_t e;
    @(negedge clk);
    A = a; B = b; C_in = cin; sub = sb; start = 1'b1;
    e.s = es; e.c = ec; e.v = ev; e.cyc = cyc + 5;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy === 1'b1 || done === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < 50) ? 32'd0 : 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] c0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; C_in = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_S", {16'h0, S}, 32'd0);
    check("rst_C_out", {31'h0, C_out}, 32'd0);
    check("rst_overflow", {31'h0, overflow}, 32'd0);
    rst = 1'b0;

    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    drain();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain();
    issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain();

    // Back-to-back: start held through ADD and DONE; operand changes during ADD must not leak in.
    @(negedge clk);
    c0 = cyc;
    A = 16'h1111; B = 16'h2222; C_in = 1'b0; start = 1'b1;
    e.s = 16'h3333; e.c = 1'b0; e.v = 1'b0; e.cyc = c0 + 5;
    q.push_back(e);
    e.s = 16'h0003; e.c = 1'b0; e.v = 1'b0; e.cyc = c0 + 10;
    q.push_back(e);
    @(negedge clk);
    A = 16'h0001; B = 16'h0002;
    repeat (5) @(negedge clk);
    start = 1'b0;
    drain();

    // Mid-operation reset: no done for the aborted add, outputs cleared.
    @(negedge clk);
    A = 16'h1111; B = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_done", {31'h0, done}, 32'd0);
    check("abort_S", {16'h0, S}, 32'd0);
    check("abort_C_out", {31'h0, C_out}, 32'd0);
    rst = 1'b0; start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done_busy", {31'h0, busy}, 32'd0);
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    drain();
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    drain();

`ifdef SERIAL_ADD_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    drain();
    issue(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    drain();
`else
    // sub is ignored in the default build.
    issue(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
    drain();
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that reuses one 4-bit `Ripple_Adder` instance, one nibble per clock, least significant nibble first. It sits directly upstream and downstream of that adder. It latches wide operands and feeds the adder's `A`, `B` and `C_in` one nibble at a time. It captures `S` and `C_out` each cycle, chains the carry through a register, and presents a registered full-width result with a start/done handshake.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit digits; operand width W = 4*NIBBLES; legal range 1..16.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous reset, active-high
- `start`  input  1  request; sampled only when `busy`=0
- `A`  input  W  operand A; latched on accepted start
- `B`  input  W  operand B; latched on accepted start
- `C_in`  input  1  carry into nibble 0; latched on accepted start
- `sub`  input  1  subtract request; latched on accepted start (see Configuration)
- `busy`  output  1  high while nibbles are being added
- `done`  output  1  one-cycle pulse; result valid
- `S`  output  W  registered sum
- `C_out`  output  1  registered carry out of bit W-1
- `overflow`  output  1  registered two's-complement overflow

## Operation
- FSM states and transitions:
  - IDLE: accepts `start`, moves to ADD.
  - ADD: nibble counter `cnt` counts 0..NIBBLES-1; after the last nibble it moves to DONE.
  - DONE: moves to IDLE, or back to ADD if `start`=1.
- Accepted start:
  - Loads the A and B shift registers; loads the B shift register with ~B when subtracting.
  - Loads the carry register with `C_in`, or with 1 when subtracting.
  - Clears `cnt`.
- Each ADD cycle:
  - The adder sees the low nibble of each shift register plus the carry register.
  - On the edge, the adder `S` nibble shifts into the result register at the top. The A and B registers shift right by 4. The adder `C_out` is written to the carry register.
- On the edge ending the last ADD cycle, the following are loaded together:
  - `S` from the result register, including the final nibble.
  - `C_out` from the adder carry.
  - `overflow` = (A[W-1] == Beff[W-1]) && (S[W-1] != A[W-1]), where Beff is B after optional inversion.
- `S`, `C_out` and `overflow` hold until the next completion. They never show partial results.
- Arithmetic is modulo 2^W. `C_out` is the unsigned carry/no-borrow flag.

## Timing
- Reset values: `busy`=0, `done`=0, `S`=0, `C_out`=0, `overflow`=0. The FSM enters IDLE and all internal registers are cleared.
- Latency:
  - Start accepted at edge 0.
  - `busy`=1 from after edge 0 to edge NIBBLES.
  - `done`=1 for exactly the cycle after edge NIBBLES.
  - Outputs are valid in that same cycle.
- `start` while `busy`=1 is ignored; operand changes during ADD are ignored.
- `start` during the DONE cycle is accepted (back-to-back): `busy` rises on the next edge, giving a throughput of one result per NIBBLES+1 cycles.
- `rst` mid-operation returns the FSM to IDLE and zeroes all outputs on that edge. The partial result is discarded and no `done` is issued.
- `rst` and `start` high together: reset wins.
- NIBBLES=1: single ADD cycle, `done` one cycle after start acceptance.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - `sub`=1 computes A + ~B + 1 (A−B) and ignores `C_in`.
  - `sub`=0 adds normally.
- Not defined:
  - The `sub` port remains but is ignored; the block always computes A+B+`C_in`.
  - No inversion logic is synthesized.

## Test plan
All scenarios use NIBBLES=4.
- A=16'h1234, B=16'h4321, C_in=0, start pulse -> `done` 4 cycles after acceptance, S=16'h5555, C_out=0, overflow=0.
- A=16'hFFFF, B=16'h0001, C_in=0 -> S=16'h0000, C_out=1, overflow=0. Confirms the carry ripples through all four nibbles.
- A=16'h7FFF, B=16'h0000, C_in=1 -> S=16'h8000, C_out=0, overflow=1.
- `start` held high across the DONE cycle with new operands 16'h0001+16'h0002 -> second `done` exactly 5 cycles after the first, S=16'h0003. `start` pulses during ADD have no effect.
- `rst` asserted at the second ADD cycle -> next edge `busy`=0, S=0, C_out=0; no `done` for the aborted operation; next start completes normally.
- With `SERIAL_ADD_SUB_EN`, sub=1, A=16'h0005, B=16'h0007 -> S=16'hFFFE, C_out=0. A=16'h0007, B=16'h0005 -> S=16'h0002, C_out=1.
